// File: rtl/bk_multiword_add_seq.sv
// Wide add/subtract sequencer: pushes one 16-bit slice per cycle, LSB
// first, through a single 16-bit Brent-Kung adder. The slice carry is
// registered and fed back as the next slice's carry-in.

// 16-bit Brent-Kung parallel-prefix adder.
module brentkung (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        carry_out
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] gp;

    // Prefix tree computed in place: up-sweep builds power-of-two group
    // (G,P) pairs, down-sweep fills the remaining prefixes. cin is folded
    // into bit 0's generate so g[i] ends up as the carry out of bit i.
    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = a ^ b;
        g[0] = g[0] | (p[0] & cin);
        for (int lv = 0; lv < 4; lv++) begin
            for (int i = 0; i < 16; i++) begin
                if (((i + 1) % (2 << lv)) == 0) begin
                    g[i]  = g[i] | (gp[i] & g[i - (1 << lv)]);
                    gp[i] = gp[i] & gp[i - (1 << lv)];
                end
            end
        end
        for (int lv = 2; lv >= 0; lv--) begin
            for (int i = 0; i < 16; i++) begin
                if ((((i + 1) % (2 << lv)) == (1 << lv)) && (i >= (3 << lv) - 1)) begin
                    g[i]  = g[i] | (gp[i] & g[i - (1 << lv)]);
                    gp[i] = gp[i] & gp[i - (1 << lv)];
                end
            end
        end
    end

    assign sum       = p ^ {g[14:0], cin};
    assign carry_out = g[15];
endmodule

module bk_multiword_add_seq #(
    parameter int WORDS = 4,
    parameter int CNT_W = $clog2(WORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                sub,
    input  logic                cin_ext,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] result,
    output logic                carry_out,
    output logic                overflow
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    // Operands held as word arrays so the slice mux is a plain word select.
    logic [WORDS-1:0][15:0] a_r;
    logic [WORDS-1:0][15:0] b_r;
    logic [WORDS-1:0][15:0] res_q;
    logic                   c_r;
    logic [CNT_W-1:0]       idx;
    logic                   cout_q;
    logic                   ovf_q;

    logic                   accept;
    logic                   last;
    logic [15:0]            bk_sum;
    logic                   bk_cout;

    brentkung u_bk (
        .a         (a_r[idx]),
        .b         (b_r[idx]),
        .cin       (c_r),
        .sum       (bk_sum),
        .carry_out (bk_cout)
    );

    assign last = (state == RUN) && (idx == LAST);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs; no accept while a result is held.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands on accept (B inverted and carry forced
    // to 1 for subtract), then write one result slice per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= 1'b0;
            idx    <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            a_r <= op_a;
            b_r <= sub ? ~op_b : op_b;
            c_r <= sub | cin_ext;
            idx <= '0;
        end else if (state == RUN) begin
            res_q[idx] <= bk_sum;
            c_r        <= bk_cout;
            if (last) begin
                cout_q <= bk_cout;
                ovf_q  <= (a_r[WORDS-1][15] == b_r[WORDS-1][15]) &&
                          (bk_sum[15] != a_r[WORDS-1][15]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Directed bench for bk_multiword_add_seq (WORDS=4). Stimulus pushes the
// hand-computed response into a queue; a monitor pops on each output
// handshake and compares.
module tb_bk_multiword_add_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         cin_ext = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        string        nm;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    bk_multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin_ext   (cin_ext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present one request for a single accept edge; optionally queue its response.
    task automatic send(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ci, input logic [W-1:0] r,
                        input logic c, input logic o, input bit push);
        exp_t e;
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!in_ready) chk({nm, " in_ready timeout"}, W'(in_ready), W'(1));
        op_a = a; op_b = b; sub = s; cin_ext = ci; in_valid = 1'b1;
        if (push) begin
            e.r = r; e.c = c; e.o = o; e.nm = nm;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid; expect WORDS.
    task automatic wait_out(input string nm);
        int k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!out_valid && k < 20);
        chk({nm, " latency"}, W'(k), W'(WORDS));
    endtask

    task automatic op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic ci, input logic [W-1:0] r,
                      input logic c, input logic o);
        send(nm, a, b, s, ci, r, c, o, 1'b1);
        wait_out(nm);
        @(posedge clk); #1;
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && out_valid && out_ready) begin
                        if (sbq.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected output: got %h want none", result);
                        end else begin
                            e = sbq.pop_front();
                            chk({e.nm, " result"}, result, e.r);
                            chk({e.nm, " carry"}, W'(carry_out), W'(e.c));
                            chk({e.nm, " overflow"}, W'(overflow), W'(e.o));
                        end
                    end
                end
            end
        join_none

        // Reset state
        #12;
        chk("reset in_ready", W'(in_ready), W'(1));
        chk("reset out_valid", W'(out_valid), W'(0));
        chk("reset result", result, '0);
        chk("reset carry", W'(carry_out), W'(0));
        chk("reset overflow", W'(overflow), W'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        op("sub borrow", 64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        op("sub equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0);
        op("add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
        op("sub ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        op("cin_ext", 64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 1'b1,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
        op("sub ignores cin", 64'h3, 64'h1, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);

        // Backpressure: result held while out_ready=0; a request waiting
        // during RUN/DONE is taken only after the handshake.
        out_ready = 1'b0;
        send("bp op1", 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0,
             64'h1212_2323_3434_4545, 1'b0, 1'b0, 1'b1);
        send_queued: begin
            exp_t e2;
            op_a = 64'h8000_0000_0000_0000; op_b = 64'h8000_0000_0000_0000;
            sub = 1'b0; cin_ext = 1'b0; in_valid = 1'b1;
            e2.r = 64'h0; e2.c = 1'b1; e2.o = 1'b1; e2.nm = "bp op2";
            sbq.push_back(e2);
        end
        for (int k = 0; k < WORDS; k++) begin
            @(posedge clk); #1;
            chk("bp in_ready run/done", W'(in_ready), W'(0));
        end
        chk("bp out_valid", W'(out_valid), W'(1));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp hold valid", W'(out_valid), W'(1));
            chk("bp hold result", result, 64'h1212_2323_3434_4545);
            chk("bp hold carry", W'(carry_out), W'(0));
            chk("bp hold overflow", W'(overflow), W'(0));
            chk("bp hold in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp in_ready after hs", W'(in_ready), W'(1));
        chk("bp out_valid after hs", W'(out_valid), W'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp queued accepted", W'(in_ready), W'(0));
        wait_out("bp op2");
        @(posedge clk); #1;

        // Reset while idx=2: outputs clear without a clock edge.
        send("aborted", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0,
             64'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("async rst in_ready", W'(in_ready), W'(1));
        chk("async rst out_valid", W'(out_valid), W'(0));
        chk("async rst result", result, '0);
        chk("async rst carry", W'(carry_out), W'(0));
        chk("async rst overflow", W'(overflow), W'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        op("after reset", 64'h1_0000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0,
           64'h1_FFFF_FFFF, 1'b0, 1'b0);

        begin
            int k = 0;
            while (sbq.size() != 0 && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            chk("scoreboard drained", W'(sbq.size()), W'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bk_multiword_add_seq.md
Name: bk_multiword_add_seq

Overview:
- Sequencer that wraps the team's 16-bit Brent-Kung adder (`brentkung`).
- Performs one wide add or subtract (16*WORDS bits) by sending one 16-bit slice per cycle through a single `brentkung` instance, LSB slice first.
- Registers the adder's carry_out between slices and feeds it back as the next slice's cin.
- Has a valid/ready handshake on the input side and the output side; sits between operand source and result consumer.

Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal range 2..16.
- CNT_W, $clog2(WORDS), width of the slice index counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present on op_a/op_b/sub/cin_ext.
- in_ready  output  1  block can accept a request.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- sub  input  1  1 = A-B, 0 = A+B.
- cin_ext  input  1  carry-in for add mode; ignored when sub=1.
- out_valid  output  1  result registers hold a completed operation.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference.
- carry_out  output  1  final carry. In sub mode, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow of the full W-bit operation.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0.
  - Internal operand registers, carry register and slice index all 0.
- Reset mid-operation: an assertion in any state aborts immediately with no partial result; the next accepted request behaves normally.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid=1 at a rising edge.
  - On accept: latch a_r=op_a, b_r = sub ? ~op_b : op_b, c_r = sub ? 1 : cin_ext; idx=0; go to RUN.
  - While in_valid=0, stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Combinational slice: the `brentkung` instance gets a=a_r[16*idx +: 16], b=b_r[16*idx +: 16], cin=c_r.
  - Each edge writes its sum into result[16*idx +: 16] and sets c_r to the adder's carry_out.
  - When idx != WORDS-1: idx increments.
  - When idx == WORDS-1:
    - carry_out takes the adder's carry_out.
    - overflow = (a_r[W-1] == b_r[W-1]) && (slice_sum[15] != a_r[W-1]).
    - Go to DONE.
  - in_valid is ignored in RUN; the request is not consumed.
- DONE:
  - out_valid=1, in_ready=0.
  - result, carry_out and overflow stay stable until the handshake.
  - On out_valid && out_ready: go to IDLE; in_ready=1 on the following cycle.
  - No bypass: a new request cannot be accepted in the same cycle as the output handshake.
- Latency:
  - Accept edge is E0; out_valid rises after edge E_WORDS (4 cycles for WORDS=4).
  - Throughput: one operation per WORDS+2 cycles when out_ready is held at 1.
- Widths:
  - All slice arithmetic is 16-bit through `brentkung`; no other adder is inferred.
  - The carry is 1 bit and wraps modulo 2^W.
  - Sub mode is two's complement: ~B plus carry-in 1.
- Operand registers are captured at accept, so changes on op_a/op_b after acceptance have no effect.
- result may show partial slices during RUN; consumers use it only while out_valid=1.

Test Plan (WORDS=4):
- Full-width carry ripple: add, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin_ext=0 -> result=0x0, carry_out=1, overflow=0; out_valid rises 4 cycles after the accept edge.
- Subtract with borrow: sub=1, a=0x5, b=0x7 -> result=0xFFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0. Also sub=1, a=b=0x1234_5678_9ABC_DEF0 -> result=0, carry_out=1.
- Signed overflow: add, a=0x7FFF_FFFF_FFFF_FFFF, b=0x1 -> result=0x8000_0000_0000_0000, overflow=1, carry_out=0. Also sub=1, a=0x8000_0000_0000_0000, b=0x1 -> overflow=1.
- Cross-slice carry and cin_ext: add, cin_ext=1, a=0x0000_0000_0000_FFFF, b=0 -> result=0x0000_0000_0001_0000, carry_out=0. With sub=1 and cin_ext=1, cin_ext is ignored (a=3, b=1 -> 2).
- Backpressure:
  - out_ready=0 for 3 cycles in DONE -> result, carry_out and overflow stable, in_ready=0.
  - in_valid=1 with new operands during RUN and DONE -> no new accept.
  - After the handshake -> in_ready=1 next cycle, and the queued request produces a correct result.
- Reset mid-RUN: drop rst_n while idx=2 -> outputs 0 and in_ready=1 asynchronously, without waiting for a clock edge. After release, the add 0x1_0000_0000 + 0xFFFF_FFFF -> 0x1_FFFF_FFFF.
